one_hot_decoder: RTL

// - Inverse of the find-first-one encoder: turns a bit index + valid flag back into an N-bit one-hot word.
// - Used on the normalize/denormalize path of the fixed-point adder to rebuild leading-one position masks.
// - 2-stage valid/ready pipeline; full throughput, backpressure-safe, no transaction loss or duplication.

---
 rtl/one_hot_decoder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/one_hot_decoder.sv
// one_hot_decoder: rebuilds an N-bit one-hot word from a bit index plus a
// non-zero flag. This is the inverse of the find-first-one encoder.
// It is a two-stage valid/ready pipeline with full throughput.
//   S1 registers {index, nz}.
//   S2 registers the decoded word and the out-of-range error flag.
// Optional feature macro: DEC_THERMO_EN adds out_mask, an LSB-filled
// thermometer mask that is registered alongside out_word.
module one_hot_decoder #(
  parameter int N = 32,
  localparam int INDEX_WIDTH = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INDEX_WIDTH-1:0] in_index,
  input  logic                   in_nz,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           out_word,
  output logic                   out_err
`ifdef DEC_THERMO_EN
  ,
  output logic [N-1:0]           out_mask
`endif
);

  // Index is in range when it names one of the N word bits. Enumerating the
  // legal values avoids a constant compare that is always true when N = 2**W.
  function automatic logic index_in_range(input logic [INDEX_WIDTH-1:0] idx);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (idx == INDEX_WIDTH'(k)) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [N-1:0] decode_word(input logic                   nz,
                                               input logic [INDEX_WIDTH-1:0] idx);
    logic [N-1:0] w;
    w = '0;
    for (int k = 0; k < N; k++) begin
      w[k] = nz && (idx == INDEX_WIDTH'(k));
    end
    return w;
  endfunction

  function automatic logic decode_err(input logic                   nz,
                                      input logic [INDEX_WIDTH-1:0] idx);
    return nz && !index_in_range(idx);
  endfunction

`ifdef DEC_THERMO_EN
  // Every bit at or below the set bit is 1. A zero word yields a zero mask,
  // which covers both the nz=0 case and the error case.
  function automatic logic [N-1:0] thermo_mask(input logic [N-1:0] w);
    logic [N-1:0] m;
    logic         acc;
    m   = '0;
    acc = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      acc  = acc | w[k];
      m[k] = acc;
    end
    return m;
  endfunction
`endif

  logic                   r_vld_p1;
  logic [INDEX_WIDTH-1:0] r_index_p1;
  logic                   r_nz_p1;
  logic                   r_vld_p2;
  logic [N-1:0]           r_word_p2;
  logic                   r_err_p2;
  logic                   w_s2_free;
  logic                   w_s1_load;
  logic                   w_s2_load;

  // S2 can take new data when it is empty or is being drained this cycle.
  // Because S2 can take data, S1 can also take data, so there is no bubble
  // on a single-cycle stall.
  assign w_s2_free = ~r_vld_p2 | out_ready;
  assign in_ready  = ~r_vld_p1 | w_s2_free;
  assign w_s1_load = in_valid & in_ready;
  assign w_s2_load = r_vld_p1 & w_s2_free;

  // Stage valids: reset clears anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      if (in_ready)  r_vld_p1 <= in_valid;
      if (w_s2_free) r_vld_p2 <= r_vld_p1;
    end
  end

  // ---- S0 -> S1: capture index and nz (only when a transfer happens) ----
  always_ff @(posedge clk) begin
    if (w_s1_load) begin
      r_index_p1 <= in_index;
      r_nz_p1    <= in_nz;
    end
  end

  // ---- S1 -> S2: decode. Outputs are zero out of reset and hold while stalled ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_p2 <= '0;
      r_err_p2  <= 1'b0;
    end else if (w_s2_load) begin
      r_word_p2 <= decode_word(r_nz_p1, r_index_p1);
      r_err_p2  <= decode_err(r_nz_p1, r_index_p1);
    end
  end

`ifdef DEC_THERMO_EN
  logic [N-1:0] r_mask_p2;

  // Thermometer mask register, loaded together with the decoded word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask_p2 <= '0;
    end else if (w_s2_load) begin
      r_mask_p2 <= thermo_mask(decode_word(r_nz_p1, r_index_p1));
    end
  end

  assign out_mask = r_mask_p2;
`endif

  assign out_valid = r_vld_p2;
  assign out_word  = r_word_p2;
  assign out_err   = r_err_p2;

endmodule
